// File: rtl/vdc_slot_arbiter_pkg.sv
// vdc_slot_arbiter_pkg: shared types and helpers for the VDC RAM slot arbiter
package vdc_slot_arbiter_pkg;

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_FILL, OP_COPY} cmd_op_t;

    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_FILL, ST_CP_RD, ST_CP_WR} eng_state_t;

    typedef enum logic [1:0] {ACT_NONE, ACT_RFSH, ACT_CH, ACT_ENG} act_t;

    function automatic logic is_write(input eng_state_t s);
        return s inside {ST_WR, ST_FILL, ST_CP_WR};
    endfunction

endpackage

// File: rtl/vdc_slot_arbiter_if.sv
// vdc_slot_arbiter_if: video fetch, CPU command and RAM signals of the slot arbiter
interface vdc_slot_arbiter_if
    import vdc_slot_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int WC_W   = 8
) ();
    logic                     slot_start;
    logic                     slot_end;
    logic                     rfsh_win;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [DATA_W-1:0]        rdata;
    logic                     cmd_valid;
    cmd_op_t                  cmd_op;
    logic                     cmd_dir;
    logic [ADDR_W-1:0]        cmd_ua;
    logic [ADDR_W-1:0]        cmd_ba;
    logic [WC_W-1:0]          cmd_wc;
    logic [DATA_W-1:0]        cmd_data;
    logic                     cmd_ready;
    logic                     busy;
    logic [ADDR_W-1:0]        ua_out;
    logic [ADDR_W-1:0]        ba_out;
    logic [DATA_W-1:0]        da_out;
    logic                     ram_rd;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_di;
    logic [DATA_W-1:0]        ram_do;
    logic [7:0]               rfsh_count;

    modport slave (
        input  slot_start, slot_end, rfsh_win, ch_req, ch_addr,
        input  cmd_valid, cmd_op, cmd_dir, cmd_ua, cmd_ba, cmd_wc, cmd_data, ram_do,
        output ch_grant, ch_rvalid, rdata, cmd_ready, busy, ua_out, ba_out, da_out,
        output ram_rd, ram_we, ram_addr, ram_di, rfsh_count
    );

    modport master (
        output slot_start, slot_end, rfsh_win, ch_req, ch_addr,
        output cmd_valid, cmd_op, cmd_dir, cmd_ua, cmd_ba, cmd_wc, cmd_data, ram_do,
        input  ch_grant, ch_rvalid, rdata, cmd_ready, busy, ua_out, ba_out, da_out,
        input  ram_rd, ram_we, ram_addr, ram_di, rfsh_count
    );
endinterface

// File: rtl/vdc_slot_arbiter_blk_engine.sv
// vdc_slot_arbiter_blk_engine: CPU block engine, one RAM access per acknowledged slot
module vdc_slot_arbiter_blk_engine
    import vdc_slot_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    input  cmd_op_t           cmd_op_i,
    input  logic              cmd_dir_i,
    input  logic [ADDR_W-1:0] cmd_ua_i,
    input  logic [ADDR_W-1:0] cmd_ba_i,
    input  logic [WC_W-1:0]   cmd_wc_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              cmd_ready_o,
    output logic [ADDR_W-1:0] ua_o,
    output logic [ADDR_W-1:0] ba_o,
    output logic [DATA_W-1:0] da_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);
    eng_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ua_q, ua_d, ba_q, ba_d, step;
    logic [DATA_W-1:0] da_q, da_d, wd_q, wd_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic              dir_q, dir_d, last;

    // +1 when counting up, all-ones (-1) when counting down
    assign step = {{(ADDR_W-1){dir_q}}, 1'b1};
    assign last = wc_q == WC_W'(1);

    // engine state and address/data/count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ua_q    <= '0;
            ba_q    <= '0;
            da_q    <= '0;
            wd_q    <= '0;
            wc_q    <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ua_q    <= ua_d;
            ba_q    <= ba_d;
            da_q    <= da_d;
            wd_q    <= wd_d;
            wc_q    <= wc_d;
            dir_q   <= dir_d;
        end
    end

    // command accept in IDLE, otherwise advance one step whenever the slot completes
    always_comb begin
        state_d = state_q;
        ua_d    = ua_q;
        ba_d    = ba_q;
        da_d    = da_q;
        wd_d    = wd_q;
        wc_d    = wc_q;
        dir_d   = dir_q;
        if (state_q == ST_IDLE && cmd_valid_i) begin
            dir_d = cmd_dir_i;
            ua_d  = cmd_ua_i;
            wd_d  = cmd_data_i;
            wc_d  = cmd_wc_i;
            ba_d  = cmd_op_i == OP_COPY ? cmd_ba_i : ba_q;
            case (cmd_op_i)
                OP_READ:  state_d = ST_RD;
                OP_WRITE: state_d = ST_WR;
                OP_FILL:  state_d = ST_FILL;
                default:  state_d = ST_CP_RD;
            endcase
        end else if (state_q != ST_IDLE && ack_i) begin
            ua_d = is_write(state_q) ? ua_q + step : ua_q;
            ba_d = state_q == ST_CP_RD ? ba_q + step : ba_q;
            da_d = state_q inside {ST_RD, ST_CP_RD} ? rdata_i : da_q;
            wc_d = state_q inside {ST_FILL, ST_CP_WR} ? wc_q - WC_W'(1) : wc_q;
            case (state_q)
                ST_WR:    state_d = ST_RD;
                ST_FILL:  state_d = last ? ST_IDLE : ST_FILL;
                ST_CP_RD: state_d = ST_CP_WR;
                ST_CP_WR: state_d = last ? ST_IDLE : ST_CP_RD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // step request looks at the post-update view so back-to-back slots issue the next access
    assign req_o       = state_d != ST_IDLE;
    assign we_o        = is_write(state_d);
    assign addr_o      = state_d == ST_CP_RD ? ba_d : ua_d;
    assign wdata_o     = state_d == ST_CP_WR ? da_d : wd_d;
    assign cmd_ready_o = state_q == ST_IDLE;
    assign ua_o        = ua_q;
    assign ba_o        = ba_q;
    assign da_o        = da_q;
endmodule

// File: rtl/vdc_slot_arbiter.sv
// vdc_slot_arbiter: one RAM access per character slot shared by video channels, block engine and refresh
module vdc_slot_arbiter
    import vdc_slot_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3,
    parameter int WC_W   = 8
) (
    input logic               clk,
    input logic               reset,
    vdc_slot_arbiter_if.slave bus
);
    act_t              act_q;
    logic [NUM_CH-1:0] grant_q, rvalid_q, ch_onehot;
    logic              ram_rd_q, ram_we_q, eng_req, eng_we, eng_ack, eng_ready, ch_done;
    logic [ADDR_W-1:0] ram_addr_q, ch_sel_addr, eng_addr;
    logic [DATA_W-1:0] ram_di_q, rdata_q, eng_wdata;
    logic [7:0]        rfsh_q;

    assign ch_onehot = bus.ch_req & (~bus.ch_req + NUM_CH'(1));
    assign eng_ack   = bus.slot_end && act_q == ACT_ENG;
    assign ch_done   = bus.slot_end && act_q == ACT_CH;

    // address of the lowest-index requesting channel
    always_comb begin
        ch_sel_addr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            ch_sel_addr = bus.ch_req[i] ? bus.ch_addr[i*ADDR_W +: ADDR_W] : ch_sel_addr;
    end

    vdc_slot_arbiter_blk_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WC_W(WC_W)) u_eng (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid_i(bus.cmd_valid),
        .cmd_op_i   (bus.cmd_op),
        .cmd_dir_i  (bus.cmd_dir),
        .cmd_ua_i   (bus.cmd_ua),
        .cmd_ba_i   (bus.cmd_ba),
        .cmd_wc_i   (bus.cmd_wc),
        .cmd_data_i (bus.cmd_data),
        .ack_i      (eng_ack),
        .rdata_i    (bus.ram_do),
        .cmd_ready_o(eng_ready),
        .ua_o       (bus.ua_out),
        .ba_o       (bus.ba_out),
        .da_o       (bus.da_out),
        .req_o      (eng_req),
        .we_o       (eng_we),
        .addr_o     (eng_addr),
        .wdata_o    (eng_wdata)
    );

    // slot bookkeeping: close the old slot, then arbitrate the new one (start overrides end)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q      <= ACT_NONE;
            grant_q    <= '0;
            rvalid_q   <= '0;
            ram_rd_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '1;
            ram_di_q   <= '0;
            rdata_q    <= '0;
            rfsh_q     <= '0;
        end else begin
            rvalid_q <= ch_done ? grant_q : '0;
            rdata_q  <= ch_done ? bus.ram_do : rdata_q;
            ram_rd_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (bus.slot_start) begin
                grant_q <= '0;
                if (bus.rfsh_win) begin
                    act_q      <= ACT_RFSH;
                    ram_addr_q <= '1;
                    rfsh_q     <= rfsh_q + 8'd1;
                end else if (|bus.ch_req) begin
                    act_q      <= ACT_CH;
                    grant_q    <= ch_onehot;
                    ram_rd_q   <= 1'b1;
                    ram_addr_q <= ch_sel_addr;
                end else if (eng_req) begin
                    act_q      <= ACT_ENG;
                    ram_rd_q   <= !eng_we;
                    ram_we_q   <= eng_we;
                    ram_addr_q <= eng_addr;
                    ram_di_q   <= eng_wdata;
                end else begin
                    act_q      <= ACT_NONE;
                    ram_addr_q <= '1;
                end
            end else if (bus.slot_end) begin
                act_q   <= ACT_NONE;
                grant_q <= '0;
            end
        end
    end

    assign bus.ch_grant   = grant_q;
    assign bus.ch_rvalid  = rvalid_q;
    assign bus.rdata      = rdata_q;
    assign bus.ram_rd     = ram_rd_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_di     = ram_di_q;
    assign bus.rfsh_count = rfsh_q;
    assign bus.cmd_ready  = eng_ready;
    assign bus.busy       = !eng_ready;
endmodule

// File: tb/tb_vdc_slot_arbiter.sv
// tb_vdc_slot_arbiter: directed slots against a queue-based model of the arbiter and block engine
module tb_vdc_slot_arbiter;
    import vdc_slot_arbiter_pkg::*;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] nua;
        logic [15:0] nba;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    vdc_slot_arbiter_if bus ();
    vdc_slot_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];
    logic [7:0] mem [0:65535];
    step_t      q[$];
    int         checks = 0;
    int         failures = 0;
    logic       cmp_en = 1'b0;
    logic [2:0] e_grant, e_rvalid, g_seen, rv_seen;
    logic       e_rd, e_we, rd_seen;
    logic [15:0] e_addr, e_ua, e_ba;
    logic [7:0] e_di, e_rdata, e_da, e_rfsh;

    always @(posedge clk) begin
        if (bus.ram_rd) bus.ram_do <= ram[bus.ram_addr];
        if (bus.ram_we) ram[bus.ram_addr] = bus.ram_di;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("grant", bus.ch_grant, e_grant);
            chk("rvalid", bus.ch_rvalid, e_rvalid);
            chk("rdata", bus.rdata, e_rdata);
            chk("ram_rd", bus.ram_rd, e_rd);
            chk("ram_we", bus.ram_we, e_we);
            chk("ram_addr", bus.ram_addr, e_addr);
            if (e_we) chk("ram_di", bus.ram_di, e_di);
            chk("busy", bus.busy, 32'(q.size() != 0));
            chk("cmd_ready", bus.cmd_ready, 32'(q.size() == 0));
            chk("ua_out", bus.ua_out, e_ua);
            chk("ba_out", bus.ba_out, e_ba);
            chk("da_out", bus.da_out, e_da);
            chk("rfsh_count", bus.rfsh_count, e_rfsh);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        e_grant = 0; e_rvalid = 0; e_rd = 0; e_we = 0; e_addr = 16'hFFFF;
        e_ua = 0; e_ba = 0; e_di = 0; e_rdata = 0; e_da = 0; e_rfsh = 0;
        q.delete();
    endtask

    function automatic step_t mk(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d,
                                 input logic [15:0] nu, input logic [15:0] nb);
        step_t s;
        s.kind = k; s.addr = a; s.data = d; s.nua = nu; s.nba = nb;
        return s;
    endfunction

    task automatic cmd(input cmd_op_t op, input logic dir, input logic [15:0] ua, input logic [15:0] ba,
                       input logic [7:0] wc, input logic [7:0] d);
        logic [15:0] s;
        int n;
        bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_dir = dir;
        bus.cmd_ua = ua; bus.cmd_ba = ba; bus.cmd_wc = wc; bus.cmd_data = d;
        tick();
        bus.cmd_valid = 0;
        if (q.size() != 0) return;
        s = dir ? 16'hFFFF : 16'h0001;
        n = wc == 0 ? 256 : int'(wc);
        e_ua = ua;
        if (op == OP_COPY) e_ba = ba;
        case (op)
            OP_READ: q.push_back(mk(0, ua, 0, ua, e_ba));
            OP_WRITE: begin
                q.push_back(mk(1, ua, d, 16'(ua + s), e_ba));
                q.push_back(mk(0, 16'(ua + s), 0, 16'(ua + s), e_ba));
            end
            OP_FILL: for (int k = 0; k < n; k++) q.push_back(mk(1, 16'(ua + k*s), d, 16'(ua + (k+1)*s), e_ba));
            default: for (int k = 0; k < n; k++) begin
                q.push_back(mk(0, 16'(ba + k*s), 0, 16'(ua + k*s), 16'(ba + (k+1)*s)));
                q.push_back(mk(2, 16'(ua + k*s), 0, 16'(ua + (k+1)*s), 16'(ba + (k+1)*s)));
            end
        endcase
    endtask

    task automatic slot(input logic rf, input logic [2:0] req, input logic [47:0] addrs);
        int act;
        step_t st;
        logic [15:0] a;
        logic [2:0] g;
        bus.slot_start = 1; bus.rfsh_win = rf; bus.ch_req = req; bus.ch_addr = addrs;
        g = 0; a = 16'hFFFF; st = '0;
        if (rf) act = 1;
        else if (req != 0) begin
            act = 2;
            for (int i = 2; i >= 0; i--) if (req[i]) begin g = 3'(1 << i); a = addrs[i*16 +: 16]; end
        end else if (q.size() != 0) begin
            act = 3; st = q[0]; a = st.addr;
        end else act = 0;
        tick();
        bus.slot_start = 0; bus.rfsh_win = 0; bus.ch_req = 0;
        g_seen = bus.ch_grant; rd_seen = bus.ram_rd;
        e_grant = g; e_addr = a;
        e_rd = act == 2 || (act == 3 && st.kind == 0);
        e_we = act == 3 && st.kind != 0;
        if (e_we) e_di = st.kind == 1 ? st.data : e_da;
        if (act == 1) e_rfsh++;
        for (int i = 0; i < 2; i++) begin tick(); e_rd = 0; e_we = 0; end
        bus.slot_end = 1;
        tick();
        bus.slot_end = 0;
        rv_seen = bus.ch_rvalid;
        e_grant = 0;
        if (act == 2) begin e_rvalid = g; e_rdata = mem[a]; end
        if (act == 3) begin
            if (st.kind == 0) e_da = mem[a]; else mem[a] = e_di;
            e_ua = st.nua; e_ba = st.nba;
            void'(q.pop_front());
        end
        tick();
        e_rvalid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin ram[i] = 8'(i) ^ 8'h3C; mem[i] = 8'(i) ^ 8'h3C; end
        bus.slot_start = 0; bus.slot_end = 0; bus.rfsh_win = 0; bus.ch_req = 0; bus.ch_addr = 0;
        bus.cmd_valid = 0; bus.cmd_op = OP_READ; bus.cmd_dir = 0; bus.cmd_ua = 0; bus.cmd_ba = 0;
        bus.cmd_wc = 0; bus.cmd_data = 0;
        reset_model();
        tick(); tick();
        reset = 0;
        tick();
        cmp_en = 1;
        chk("rst_ram_addr", bus.ram_addr, 16'hFFFF);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rfsh", bus.rfsh_count, 0);

        cmd(OP_FILL, 0, 16'h1000, 16'h0000, 8'd3, 8'hAA);
        cmd(OP_READ, 0, 16'h3333, 16'h0000, 8'd0, 8'h00);
        slot(0, 3'b110, {16'h0077, 16'h0042, 16'h0000});
        chk("pri_grant", g_seen, 3'b010);
        chk("pri_rvalid", rv_seen, 3'b010);
        chk("pri_rdata", bus.rdata, 8'h7E);
        chk("pri_no_step", bus.ua_out, 16'h1000);
        slot(0, 3'b101, {16'h0005, 16'h0000, 16'h0010});
        chk("pri_low_idx", g_seen, 3'b001);
        for (int i = 0; i < 3; i++) slot(0, 0, 0);
        chk("fill_ua", bus.ua_out, 16'h1003);
        chk("fill_busy", bus.busy, 0);
        chk("fill_ram", ram[16'h1002], 8'hAA);
        slot(0, 0, 0);

        cmd(OP_COPY, 1, 16'h2001, 16'h0001, 8'd2, 8'h00);
        for (int i = 0; i < 4; i++) slot(0, 0, 0);
        chk("copy_ba", bus.ba_out, 16'hFFFF);
        chk("copy_ua", bus.ua_out, 16'h1FFF);
        chk("copy_ram1", ram[16'h2001], 8'h3D);
        chk("copy_ram0", ram[16'h2000], 8'h3C);

        cmd(OP_READ, 0, 16'h1001, 16'h0000, 8'd0, 8'h00);
        slot(0, 0, 0);
        chk("read_da", bus.da_out, 8'hAA);

        cmd(OP_WRITE, 0, 16'hFFFF, 16'h0000, 8'd0, 8'h55);
        slot(0, 0, 0);
        slot(0, 0, 0);
        chk("write_ram", ram[16'hFFFF], 8'h55);
        chk("write_ua", bus.ua_out, 16'h0000);
        chk("write_da", bus.da_out, 8'h3C);

        cmd(OP_COPY, 0, 16'h3000, 16'h1000, 8'd0, 8'h00);
        slot(0, 0, 0);
        bus.slot_start = 1;
        tick();
        bus.slot_start = 0;
        chk("pre_rst_we", bus.ram_we, 1);
        reset = 1;
        #1;
        chk("rst_mid_we", bus.ram_we, 0);
        chk("rst_mid_rd", bus.ram_rd, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_ua", bus.ua_out, 16'h0000);
        chk("rst_mid_ready", bus.cmd_ready, 1);
        reset_model();
        tick(); tick();
        reset = 0;
        tick();

        for (int i = 0; i < 255; i++) slot(1, 0, 0);
        chk("rfsh_ff", bus.rfsh_count, 8'hFF);
        slot(1, 3'b001, {32'h0, 16'h0123});
        chk("rfsh_no_grant", g_seen, 0);
        chk("rfsh_no_rd", rd_seen, 0);
        chk("rfsh_wrap", bus.rfsh_count, 8'h00);
        slot(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
